// File: rtl/reaper_alu.sv
// rtl/reaper_alu.sv - signed 32-bit Reaper ALU with registered result and condition flag
// Outputs update one Fast_Clock edge after operands and ALU_Op are presented.
module reaper_alu #(
  parameter int WIDTH = 32
) (
  input  logic                    Fast_Clock,
  input  logic                    Reset,
  input  logic signed [WIDTH-1:0] Input_1,
  input  logic signed [WIDTH-1:0] Input_2,
  input  logic        [4:0]       ALU_Op,
  output logic signed [WIDTH-1:0] Result,
  output logic                    True
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic signed [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_MUL    = 5'd2,
    OP_DIV    = 5'd3,
    OP_MOD    = 5'd4,
    OP_AND    = 5'd5,
    OP_OR     = 5'd6,
    OP_XOR    = 5'd7,
    OP_NOR    = 5'd8,
    OP_NOT    = 5'd9,
    OP_SLL    = 5'd10,
    OP_SRL    = 5'd11,
    OP_SRA    = 5'd12,
    OP_EQ     = 5'd13,
    OP_NE     = 5'd14,
    OP_LT     = 5'd15,
    OP_LE     = 5'd16,
    OP_GT     = 5'd17,
    OP_GE     = 5'd18,
    OP_PASS_A = 5'd19,
    OP_PASS_B = 5'd20
  } alu_op_e;

  logic signed [WIDTH-1:0] result_d, result_q;
  logic                    true_d, true_q;
  logic                    cmp;
  logic        [SHW-1:0]   shamt;
  logic                    div_by_zero;
  logic                    div_ovf;

  // Only the low bits of B select the shift amount; upper bits are ignored.
  assign shamt       = Input_2[SHW-1:0];
  assign div_by_zero = (Input_2 == '0);
  // MIN_NEG / -1 cannot be represented; it wraps back to MIN_NEG with a zero remainder.
  assign div_ovf     = (Input_1 == MIN_NEG) && (Input_2 == '1);

  always_comb begin
    result_d = '0;
    true_d   = 1'b0;
    cmp      = 1'b0;
    case (alu_op_e'(ALU_Op))
      OP_ADD:    result_d = Input_1 + Input_2;
      OP_SUB:    result_d = Input_1 - Input_2;
      OP_MUL:    result_d = Input_1 * Input_2;
      OP_DIV: begin
        if (div_by_zero)  result_d = '0;
        else if (div_ovf) result_d = MIN_NEG;
        else              result_d = Input_1 / Input_2;
      end
      OP_MOD: begin
        if (div_by_zero || div_ovf) result_d = '0;
        else                        result_d = Input_1 % Input_2;
      end
      OP_AND:    result_d = Input_1 & Input_2;
      OP_OR:     result_d = Input_1 | Input_2;
      OP_XOR:    result_d = Input_1 ^ Input_2;
      OP_NOR:    result_d = ~(Input_1 | Input_2);
      OP_NOT:    result_d = ~Input_1;
      OP_SLL:    result_d = Input_1 << shamt;
      OP_SRL:    result_d = Input_1 >> shamt;
      OP_SRA:    result_d = Input_1 >>> shamt;
      OP_EQ, OP_NE, OP_LT, OP_LE, OP_GT, OP_GE: begin
        case (alu_op_e'(ALU_Op))
          OP_EQ:   cmp = (Input_1 == Input_2);
          OP_NE:   cmp = (Input_1 != Input_2);
          OP_LT:   cmp = (Input_1 <  Input_2);
          OP_LE:   cmp = (Input_1 <= Input_2);
          OP_GT:   cmp = (Input_1 >  Input_2);
          default: cmp = (Input_1 >= Input_2);
        endcase
        true_d   = cmp;
        result_d = {{(WIDTH-1){1'b0}}, cmp};
      end
      OP_PASS_A: result_d = Input_1;
      OP_PASS_B: result_d = Input_2;
      default: begin
        result_d = '0;
        true_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Fast_Clock or negedge Reset) begin
    if (!Reset) begin
      result_q <= '0;
      true_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      true_q   <= true_d;
    end
  end

  assign Result = result_q;
  assign True   = true_q;

endmodule

// File: tb/tb_reaper_alu.sv
// tb/tb_reaper_alu.sv - scoreboard bench for reaper_alu with a behavioural reference model
// Driver pushes expectations at issue time; a monitor pops one per clock edge.
module tb_reaper_alu;

  logic               clk;
  logic               rst_n;
  logic signed [31:0] a_in;
  logic signed [31:0] b_in;
  logic        [4:0]  op_in;
  logic signed [31:0] res_out;
  logic               true_out;

  typedef struct {
    logic [31:0] res;
    logic        tru;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  reaper_alu #(.WIDTH(32)) dut (
    .Fast_Clock(clk),
    .Reset     (rst_n),
    .Input_1   (a_in),
    .Input_2   (b_in),
    .ALU_Op    (op_in),
    .Result    (res_out),
    .True      (true_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference computed from the arithmetic rules using 64-bit integers.
  function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input string name);
    exp_t        e;
    int          sa = a;
    int          sb = b;
    longint      la = sa;
    longint      lb = sb;
    int unsigned sh = b & 32'd31;
    logic [31:0] r = '0;
    bit          t = 1'b0;
    case (op)
      5'd0:  r = a + b;
      5'd1:  r = a - b;
      5'd2:  r = 32'(la * lb);
      5'd3:  r = (lb == 0) ? 32'd0 : 32'(la / lb);
      5'd4:  r = (lb == 0) ? 32'd0 : 32'(la % lb);
      5'd5:  r = a & b;
      5'd6:  r = a | b;
      5'd7:  r = a ^ b;
      5'd8:  r = ~(a | b);
      5'd9:  r = ~a;
      5'd10: r = a << sh;
      5'd11: r = a >> sh;
      5'd12: r = sa >>> sh;
      5'd13: t = (sa == sb);
      5'd14: t = (sa != sb);
      5'd15: t = (sa <  sb);
      5'd16: t = (sa <= sb);
      5'd17: t = (sa >  sb);
      5'd18: t = (sa >= sb);
      5'd19: r = a;
      5'd20: r = b;
      default: r = '0;
    endcase
    if (op >= 5'd13 && op <= 5'd18) r = {31'd0, t};
    e.res  = r;
    e.tru  = t;
    e.name = name;
    return e;
  endfunction

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input string name);
    @(negedge clk);
    op_in = op;
    a_in  = a;
    b_in  = b;
    exp_q.push_back(model(op, a, b, name));
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.name, ".result"}, res_out, e.res);
      chk({e.name, ".true"}, {31'd0, true_out}, {31'd0, e.tru});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'd0;
      3: return 32'($urandom_range(0, 40));
      4: return 32'(-int'($urandom_range(0, 40)));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    op_in = 5'd0;
    a_in  = 32'sd5;
    b_in  = 32'sd7;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.result", res_out, 32'd0);
    chk("reset.true", {31'd0, true_out}, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(model(5'd0, 32'd5, 32'd7, "reset_release_add"));

    issue(5'd0,  32'h7FFF_FFFF, 32'd1,           "add_wrap");
    issue(5'd1,  32'd3,         32'd10,          "sub_neg");
    issue(5'd2,  -32'sd6,       32'd7,           "mul_neg");
    issue(5'd2,  32'h0001_0000, 32'h0001_0000,   "mul_wrap");
    issue(5'd3,  -32'sd7,       32'd2,           "div_trunc");
    issue(5'd4,  -32'sd7,       32'd2,           "mod_sign");
    issue(5'd3,  32'd9,         32'd0,           "div_zero");
    issue(5'd4,  32'd9,         32'd0,           "mod_zero");
    issue(5'd3,  32'h8000_0000, 32'hFFFF_FFFF,   "div_ovf");
    issue(5'd4,  32'h8000_0000, 32'hFFFF_FFFF,   "mod_ovf");
    issue(5'd12, 32'h8000_0000, 32'd4,           "sra");
    issue(5'd11, 32'h8000_0000, 32'd4,           "srl");
    issue(5'd10, 32'd1,         32'd33,          "sll_mask");
    issue(5'd9,  32'd0,         32'h1234_5678,   "not");
    issue(5'd8,  32'd0,         32'd0,           "nor");
    issue(5'd15, 32'hFFFF_FFFF, 32'd1,           "lt_signed");
    issue(5'd17, 32'hFFFF_FFFF, 32'd1,           "gt_signed");
    issue(5'd13, 32'd5,         32'd5,           "eq");
    issue(5'd18, 32'd5,         32'd5,           "ge");
    issue(5'd0,  32'd5,         32'd5,           "add_after_cmp");
    issue(5'd25, 32'd123,       32'd456,         "reserved");
    issue(5'd20, 32'hDEAD_BEEF, 32'h0000_1234,   "pass_b");
    issue(5'd19, 32'hDEAD_BEEF, 32'h0000_1234,   "pass_a");

    // Reset mid-operation: the operation in flight is discarded, output clears at once.
    @(negedge clk);
    op_in = 5'd0;
    a_in  = 32'd100;
    b_in  = 32'd1;
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset.result", res_out, 32'd0);
    chk("async_reset.true", {31'd0, true_out}, 32'd0);
    @(posedge clk);
    #1;
    chk("held_reset.result", res_out, 32'd0);
    @(negedge clk);
    op_in = 5'd16;
    a_in  = 32'd4;
    b_in  = 32'd9;
    rst_n = 1'b1;
    exp_q.push_back(model(5'd16, 32'd4, 32'd9, "post_reset_le"));

    for (int i = 0; i < 400; i++) begin
      issue(5'($urandom_range(0, 31)), rand_operand(), rand_operand(), $sformatf("rand%0d", i));
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations outstanding, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reaper_alu.md
Name: reaper_alu

Overview:
- Signed 32-bit integer ALU for the single-cycle Reaper processor datapath.
- Operand 1 comes from the register file.
- Operand 2 is either a register or the extended immediate.
- Produces an arithmetic/logic result, used as the RAM address or register write-back, and a condition flag that drives branch decisions.
- Outputs are registered on the fast clock, so they are settled well before the slow (instruction) clock edge.

Parameters:
- WIDTH, 32, operand/result width; only 32 is required to be supported.

Ports:
- Fast_Clock  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Input_1  input  32  signed operand A.
- Input_2  input  32  signed operand B.
- ALU_Op  input  5  operation select.
- Result  output  32  signed registered result.
- True  output  1  registered condition flag.

Behaviour:
- Reset low: Result = 0 and True = 0 immediately, asynchronously; held while Reset is low.
- Otherwise, on each rising Fast_Clock edge, Result and True load the combinational function of the current Input_1, Input_2 and ALU_Op.
- Latency is exactly 1 Fast_Clock cycle. There is no handshake; a new operation is accepted every cycle.
- All arithmetic is two's complement and wraps modulo 2^32. There are no overflow flags.
- Opcode map (ALU_Op decimal):
  - 0 ADD: A+B.
  - 1 SUB: A-B.
  - 2 MUL: low 32 bits of the signed product.
  - 3 DIV: signed quotient, truncated toward zero.
  - 4 MOD: signed remainder; its sign follows A.
  - 5 AND, 6 OR, 7 XOR, 8 NOR: bitwise.
  - 9 NOT: ~A (B ignored).
  - 10 SLL: A << B[4:0].
  - 11 SRL: logical A >> B[4:0].
  - 12 SRA: arithmetic A >>> B[4:0].
  - 13 EQ, 14 NE, 15 LT, 16 LE, 17 GT, 18 GE: signed compare of A vs B.
  - 19 PASS_A: A.
  - 20 PASS_B: B (load immediate).
  - 21–31: reserved.
- Compare ops (13–18): True = compare outcome; Result = 1 if true, else 0.
- All non-compare ops: True = 0.
- Reserved ops: Result = 0, True = 0.
- Divide by zero (B = 0): DIV and MOD return Result = 0.
- DIV with A = -2147483648 and B = -1 returns -2147483648; MOD in that case returns 0.
- Shifts use only B[4:0]; B[31:5] is ignored (a shift of 32 acts as a shift of 0).
- Reset asserted mid-operation discards the in-flight result. The first edge after Reset releases produces the result for the inputs present at that edge.

Test Plan:
- Reset:
  - Hold Reset=0 with ADD 5+7 applied → Result=0, True=0.
  - Release Reset → after 1 edge, Result=12.
- Arithmetic wrap:
  - ADD 0x7FFFFFFF+1 → 0x80000000.
  - SUB 3-10 → -7.
  - MUL -6*7 → -42.
  - MUL 0x10000*0x10000 → 0.
- Divide:
  - DIV -7/2 → -3.
  - MOD -7%2 → -1.
  - DIV 9/0 → 0.
  - MOD 9%0 → 0.
  - DIV -2147483648/-1 → -2147483648.
- Shifts/logic:
  - SRA 0x80000000 by 4 → 0xF8000000.
  - SRL by 4 → 0x08000000.
  - SLL 1 by 33 → 2 (uses B[4:0]=1).
  - NOT 0 → -1.
  - NOR 0,0 → -1.
- Compares:
  - LT -1 vs 1 → True=1, Result=1.
  - GT -1 vs 1 → True=0, Result=0.
  - EQ 5,5 → True=1.
  - GE 5,5 → True=1.
  - Then ADD → True=0.
- Reserved/pass:
  - ALU_Op=25 → Result=0, True=0.
  - PASS_B with B=0x1234 → 0x1234.
  - Back-to-back different ops on consecutive cycles → each result appears exactly one edge later.
